// File: rtl/fp32_pkg.sv
// Shared types and constants for the binary32 add/subtract datapath.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND
  } addsub_state_t;

  localparam int          FP32_EXP_BIAS = 127;
  localparam int          FP32_EXP_MAX  = 255;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF     = 32'h7F800000;
  localparam logic [31:0] FP32_MAXFIN   = 32'h7F7FFFFF;

  // Operation select; any code other than OP_SUB adds.
  localparam logic [1:0]  OP_ADD        = 2'b10;
  localparam logic [1:0]  OP_SUB        = 2'b01;
  localparam logic [31:0] NAN_CANON     = FP32_QNAN;

endpackage

// File: rtl/fp_lzc24.sv
// Combinational leading-zero counter for a 24-bit significand; 24 for zero.
module fp_lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  cnt
);

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (din[i]) cnt = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp32_addsub_unit.sv
// Multi-cycle IEEE-754 binary32 adder/subtractor with a fixed 6-cycle latency.
// Build option: define ADDSUB_RNE_EN for round-to-nearest-even; otherwise the
// unit rounds toward zero and saturates overflow to the largest finite value.
module fp32_addsub_unit
  import fp32_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  OP,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic        FLAG_OVF,
  output logic        FLAG_UNF,
  output logic        FLAG_INV,
  output logic        FLAG_INX
);

  addsub_state_t state_q, state_d;
  logic          done_q;
  logic          accept;

  fp32_t         a_q, b_q;
  logic [1:0]    op_q;

  // UNPACK results
  logic          u_sb, u_a_nan, u_b_nan, u_a_inf, u_b_inf, u_a_zero, u_b_zero;
  logic          u_spec, u_inv;
  logic [31:0]   u_res;
  logic [23:0]   u_siga, u_sigb;
  logic          spec_p0, spec_inv_p0, sa_p0, sb_p0;
  logic [31:0]   spec_res_p0;
  logic [7:0]    ea_p0, eb_p0;
  logic [23:0]   siga_p0, sigb_p0;

  // ALIGN results
  logic          al_a_ge, al_xs, al_ys;
  logic [7:0]    al_xe, al_ye, al_diff;
  logic [23:0]   al_xsig, al_ysig;
  logic [53:0]   al_wide;
  logic [26:0]   al_my;
  logic          spec_p1, spec_inv_p1, sx_p1, sub_p1;
  logic [31:0]   spec_res_p1;
  logic [7:0]    ex_p1;
  logic [26:0]   mx_p1, my_p1;

  // ADD results
  logic [27:0]   ad_sum;
  logic          spec_p2, spec_inv_p2, sign_p2;
  logic [31:0]   spec_res_p2;
  logic [7:0]    ex_p2;
  logic [27:0]   sum_p2;

  // NORM results
  logic [4:0]         nm_lzc;
  logic [26:0]        nm_m;
  logic signed [9:0]  nm_exp;
  logic               nm_byp;
  logic [31:0]        nm_byp_res;
  logic [3:0]         nm_byp_flg;
  logic               byp_p3, sign_p3;
  logic [31:0]        byp_res_p3;
  logic [3:0]         byp_flg_p3;
  logic signed [9:0]  exn_p3;
  logic [26:0]        m_p3;

  // ROUND result: {ovf, unf, inv, inx, result}
  logic [35:0]   rnd_w;

  // Rounds a normalised 27-bit significand (24 + G/R/S) and packs the word.
  function automatic logic [35:0] fp_round(input logic              sign,
                                           input logic signed [9:0] exp_in,
                                           input logic [26:0]       m);
    logic [24:0]       m25;
    logic [22:0]       frac;
    logic signed [9:0] e;
    logic              inx;
    logic              up;
    inx = |m[2:0];
`ifdef ADDSUB_RNE_EN
    up = m[2] & (m[1] | m[0] | m[3]);
`else
    up = 1'b0;
`endif
    m25 = {1'b0, m[26:3]} + {24'b0, up};
    e   = exp_in;
    if (m25[24]) begin
      frac = m25[23:1];
      e    = e + 10'sd1;
    end else begin
      frac = m25[22:0];
    end
    if (e >= 10'(FP32_EXP_MAX)) begin
`ifdef ADDSUB_RNE_EN
      fp_round = {4'b1001, sign, FP32_PINF[30:0]};
`else
      fp_round = {4'b1001, sign, FP32_MAXFIN[30:0]};
`endif
    end else begin
      fp_round = {3'b000, inx, sign, e[7:0], frac};
    end
  endfunction

  fp_lzc24 u_lzc (
    .din (sum_p2[26:3]),
    .cnt (nm_lzc)
  );

  assign BUSY   = (state_q != ST_IDLE) | done_q;
  assign DONE   = done_q;
  assign accept = (state_q == ST_IDLE) & START & ~done_q;

  // Next-state logic: fixed walk through the five work states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_UNPACK;
      ST_UNPACK: state_d = ST_ALIGN;
      ST_ALIGN:  state_d = ST_ADD;
      ST_ADD:    state_d = ST_NORM;
      ST_NORM:   state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control state and architectural outputs; reset discards any operation.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      RESULT   <= '0;
      FLAG_OVF <= 1'b0;
      FLAG_UNF <= 1'b0;
      FLAG_INV <= 1'b0;
      FLAG_INX <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_ROUND);
      if (state_q == ST_ROUND) begin
        {FLAG_OVF, FLAG_UNF, FLAG_INV, FLAG_INX, RESULT} <= rnd_w;
      end
    end
  end

  // ---- UNPACK: classify operands, resolve specials, build significands ----
  // Special-value classification; denormals are treated as signed zeros.
  always_comb begin
    u_sb     = b_q.sign ^ (op_q == OP_SUB);
    u_a_zero = (a_q.exp == 8'h00);
    u_b_zero = (b_q.exp == 8'h00);
    u_a_inf  = (a_q.exp == 8'hFF) && (a_q.mant == 23'd0);
    u_b_inf  = (b_q.exp == 8'hFF) && (b_q.mant == 23'd0);
    u_a_nan  = (a_q.exp == 8'hFF) && (a_q.mant != 23'd0);
    u_b_nan  = (b_q.exp == 8'hFF) && (b_q.mant != 23'd0);
    u_siga   = u_a_zero ? 24'd0 : {1'b1, a_q.mant};
    u_sigb   = u_b_zero ? 24'd0 : {1'b1, b_q.mant};
    u_spec   = 1'b1;
    u_inv    = 1'b0;
    u_res    = '0;
    if (u_a_nan || u_b_nan) begin
      u_res = NAN_CANON;
      u_inv = 1'b1;
    end else if (u_a_inf && u_b_inf && (a_q.sign != u_sb)) begin
      u_res = NAN_CANON;
      u_inv = 1'b1;
    end else if (u_a_inf) begin
      u_res = {a_q.sign, FP32_PINF[30:0]};
    end else if (u_b_inf) begin
      u_res = {u_sb, FP32_PINF[30:0]};
    end else if (u_a_zero && u_b_zero) begin
      u_res = {a_q.sign & u_sb, 31'd0};
    end else begin
      u_spec = 1'b0;
    end
  end

  // ---- ALIGN: order by magnitude, shift smaller into G/R/S field ----
  // Operand swap and sticky-preserving right shift of the smaller significand.
  always_comb begin
    al_a_ge = {ea_p0, siga_p0} >= {eb_p0, sigb_p0};
    al_xs   = al_a_ge ? sa_p0   : sb_p0;
    al_ys   = al_a_ge ? sb_p0   : sa_p0;
    al_xe   = al_a_ge ? ea_p0   : eb_p0;
    al_ye   = al_a_ge ? eb_p0   : ea_p0;
    al_xsig = al_a_ge ? siga_p0 : sigb_p0;
    al_ysig = al_a_ge ? sigb_p0 : siga_p0;
    al_diff = al_xe - al_ye;
    al_wide = {al_ysig, 30'd0} >> al_diff;
    if (al_diff > 8'd26) al_my = {26'd0, |al_ysig};
    else                 al_my = {al_wide[53:28], |al_wide[27:0]};
  end

  // ---- ADD: magnitude add/subtract, X is never smaller than Y ----
  // Effective operation chosen from the two effective signs.
  always_comb begin
    if (sub_p1) ad_sum = {1'b0, mx_p1} - {1'b0, my_p1};
    else        ad_sum = {1'b0, mx_p1} + {1'b0, my_p1};
  end

  // ---- NORM: renormalise, detect exact zero and underflow ----
  // Carry shifts right with sticky kept; otherwise shift left by the LZC.
  always_comb begin
    nm_byp     = 1'b0;
    nm_byp_res = '0;
    nm_byp_flg = '0;
    if (sum_p2[27]) begin
      nm_m   = {sum_p2[27:2], sum_p2[1] | sum_p2[0]};
      nm_exp = $signed({2'b00, ex_p2}) + 10'sd1;
    end else begin
      nm_m   = sum_p2[26:0] << nm_lzc;
      nm_exp = $signed({2'b00, ex_p2}) - $signed({5'b00000, nm_lzc});
    end
    if (spec_p2) begin
      nm_byp     = 1'b1;
      nm_byp_res = spec_res_p2;
      nm_byp_flg = {2'b00, spec_inv_p2, 1'b0};
    end else if (sum_p2 == 28'd0) begin
      nm_byp     = 1'b1;
    end else if (nm_exp <= 10'sd0) begin
      nm_byp     = 1'b1;
      nm_byp_res = {sign_p2, 31'd0};
      nm_byp_flg = 4'b0101;
    end
  end

  // ---- ROUND: apply rounding mode unless the result was already decided ----
  // Final word selection ahead of the output register.
  always_comb begin
    if (byp_p3) rnd_w = {byp_flg_p3, byp_res_p3};
    else        rnd_w = fp_round(sign_p3, exn_p3, m_p3);
  end

  // Datapath stage registers, each loaded in its own FSM state.
  always_ff @(posedge CLK) begin
    if (accept) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= OP;
    end
    if (state_q == ST_UNPACK) begin
      spec_p0     <= u_spec;
      spec_inv_p0 <= u_inv;
      spec_res_p0 <= u_res;
      sa_p0       <= a_q.sign;
      sb_p0       <= u_sb;
      ea_p0       <= a_q.exp;
      eb_p0       <= b_q.exp;
      siga_p0     <= u_siga;
      sigb_p0     <= u_sigb;
    end
    if (state_q == ST_ALIGN) begin
      spec_p1     <= spec_p0;
      spec_inv_p1 <= spec_inv_p0;
      spec_res_p1 <= spec_res_p0;
      sx_p1       <= al_xs;
      sub_p1      <= al_xs ^ al_ys;
      ex_p1       <= al_xe;
      mx_p1       <= {al_xsig, 3'b000};
      my_p1       <= al_my;
    end
    if (state_q == ST_ADD) begin
      spec_p2     <= spec_p1;
      spec_inv_p2 <= spec_inv_p1;
      spec_res_p2 <= spec_res_p1;
      sign_p2     <= sx_p1;
      ex_p2       <= ex_p1;
      sum_p2      <= ad_sum;
    end
    if (state_q == ST_NORM) begin
      byp_p3      <= nm_byp;
      byp_res_p3  <= nm_byp_res;
      byp_flg_p3  <= nm_byp_flg;
      sign_p3     <= sign_p2;
      exn_p3      <= nm_exp;
      m_p3        <= nm_m;
    end
  end

endmodule

// File: tb/tb_fp32_addsub_unit.sv
// Self-checking bench for fp32_addsub_unit: directed vectors with literal
// results plus an exact-arithmetic reference model checked on every DONE.
module tb_fp32_addsub_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [1:0]  OP = '0;
  logic        BUSY, DONE, FLAG_OVF, FLAG_UNF, FLAG_INV, FLAG_INX;
  logic [31:0] RESULT;

  int          nvec = 0;
  int          nerr = 0;
  logic [35:0] expq[$];
  logic [35:0] exp_m;

`ifdef ADDSUB_RNE_EN
  localparam logic [31:0] OVF_RES  = 32'h7F800000;
  localparam logic [31:0] TIE_RES  = 32'h3F800002;
  localparam logic [31:0] HALF_RES = 32'h3F800000;
`else
  localparam logic [31:0] OVF_RES  = 32'h7F7FFFFF;
  localparam logic [31:0] TIE_RES  = 32'h3F800001;
  localparam logic [31:0] HALF_RES = 32'h3F7FFFFF;
`endif

  fp32_addsub_unit dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
    .A        (A),
    .B        (B),
    .OP       (OP),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT),
    .FLAG_OVF (FLAG_OVF),
    .FLAG_UNF (FLAG_UNF),
    .FLAG_INV (FLAG_INV),
    .FLAG_INX (FLAG_INX)
  );

  always #5 CLK = ~CLK;

  function automatic logic [35:0] dut_out();
    return {FLAG_OVF, FLAG_UNF, FLAG_INV, FLAG_INX, RESULT};
  endfunction

  // Reference: exact sum as a scaled integer (LSB = 2^-149), then rounded.
  // Returns {ovf, unf, inv, inx, result}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    logic               sa, sb, an, bn, ai, bi, az, bz, sgn, inx, up;
    logic signed [299:0] va, vb, s;
    logic [299:0]        mag, q, rem, half;
    int                  p, e;
    sa = a[31];
    sb = b[31] ^ (op == 2'b01);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    if (an || bn) return {4'b0010, 32'h7FC00000};
    if (ai && bi && (sa != sb)) return {4'b0010, 32'h7FC00000};
    if (ai) return {4'b0000, sa, 8'hFF, 23'd0};
    if (bi) return {4'b0000, sb, 8'hFF, 23'd0};
    if (az && bz) return {4'b0000, sa & sb, 31'd0};
    va = az ? '0 : (300'({1'b1, a[22:0]}) << (a[30:23] - 8'd1));
    vb = bz ? '0 : (300'({1'b1, b[22:0]}) << (b[30:23] - 8'd1));
    if (sa) va = -va;
    if (sb) vb = -vb;
    s = va + vb;
    if (s == 0) return '0;
    sgn = (s < 0);
    if (sgn) mag = -s;
    else     mag = s;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return {4'b0101, sgn, 31'd0};
    q   = mag >> (p - 23);
    rem = mag - (q << (p - 23));
    inx = (rem != 0);
    up  = 1'b0;
`ifdef ADDSUB_RNE_EN
    if (p >= 24) begin
      half = 300'd1 << (p - 24);
      up   = (rem > half) || ((rem == half) && q[0]);
    end
`endif
    q = q + 300'(up);
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
`ifdef ADDSUB_RNE_EN
      return {4'b1001, sgn, 8'hFF, 23'd0};
`else
      return {4'b1001, sgn, 31'h7F7FFFFF};
`endif
    end
    return {3'b000, inx, sgn, 8'(e), q[22:0]};
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got result=%h flags(ovf,unf,inv,inx)=%b, want result=%h flags=%b",
               name, act[31:0], act[35:32], want[31:0], want[35:32]);
    end
  endtask

  task automatic check_bits(input string name, input logic [1:0] act, input logic [1:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got {BUSY,DONE}=%b, want %b", name, act, want);
    end
  endtask

  // Every DONE is checked against the oldest pending model result.
  always @(negedge CLK) begin
    if (DONE) begin
      if (expq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_done: got DONE=1 result=%h, want no DONE", RESULT);
      end else begin
        exp_m = expq.pop_front();
        check("model", dut_out(), exp_m);
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge after DONE.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [35:0] lit, input bit use_lit,
                       input bit scramble);
    int k;
    bit got;
    check_bits({name, " idle"}, {BUSY, DONE}, 2'b00);
    A = a; B = b; OP = op; START = 1'b1;
    expq.push_back(model(a, b, op));
    @(posedge CLK);
    #1;
    START = 1'b0;
    if (scramble) begin
      A = $urandom; B = $urandom; OP = 2'($urandom);
    end
    got = 1'b0;
    for (k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k == 1) check_bits({name, " busy1"}, {BUSY, DONE}, 2'b10);
      if (DONE) begin
        got = 1'b1;
        break;
      end
    end
    nvec++;
    if (!got || k != 6) begin
      nerr++;
      $display("FAIL %s latency: got DONE at cycle %0d (seen=%0d), want cycle 6", name, k, got);
    end
    if (got) begin
      check_bits({name, " done"}, {BUSY, DONE}, 2'b11);
      if (use_lit) check(name, dut_out(), lit);
    end
    @(negedge CLK);
  endtask

  task automatic reset_abort();
    A = 32'h3F800000; B = 32'h40000000; OP = 2'b10; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("reset_async_out", dut_out(), '0);
    check_bits("reset_async_ctl", {BUSY, DONE}, 2'b00);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (10) @(negedge CLK);
    check("reset_abort_out", dut_out(), '0);
    check_bits("reset_abort_ctl", {BUSY, DONE}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea, eb;
    logic [31:0] ra, rb;
    repeat (3) @(negedge CLK);
    check("reset_out", dut_out(), '0);
    check_bits("reset_ctl", {BUSY, DONE}, 2'b00);
    RESET_N = 1'b1;
    @(negedge CLK);

    do_op("1+2",      32'h3F800000, 32'h40000000, 2'b10, {4'b0000, 32'h40400000}, 1, 0);
    do_op("1-1",      32'h3F800000, 32'h3F800000, 2'b01, {4'b0000, 32'h00000000}, 1, 0);
    do_op("1-1_scr",  32'h3F800000, 32'h3F800000, 2'b01, {4'b0000, 32'h00000000}, 1, 1);
    do_op("max+max",  32'h7F7FFFFF, 32'h7F7FFFFF, 2'b10, {4'b1001, OVF_RES},       1, 0);
    do_op("inf-inf",  32'h7F800000, 32'h7F800000, 2'b01, {4'b0010, 32'h7FC00000}, 1, 0);
    do_op("snan+1",   32'h7FA00000, 32'h3F800000, 2'b10, {4'b0010, 32'h7FC00000}, 1, 0);
    do_op("tie",      32'h3F800001, 32'h33800000, 2'b10, {4'b0001, TIE_RES},       1, 0);
    do_op("op00_add", 32'h40000000, 32'hBF800000, 2'b00, {4'b0000, 32'h3F800000}, 1, 0);
    do_op("op11_add", 32'hC0400000, 32'h3F800000, 2'b11, {4'b0000, 32'hC0000000}, 1, 0);
    do_op("-0+-0",    32'h80000000, 32'h80000000, 2'b10, {4'b0000, 32'h80000000}, 1, 0);
    do_op("+0+-0",    32'h00000000, 32'h80000000, 2'b10, {4'b0000, 32'h00000000}, 1, 0);
    do_op("-0-+0",    32'h80000000, 32'h00000000, 2'b01, {4'b0000, 32'h80000000}, 1, 0);
    do_op("inf+1",    32'h7F800000, 32'h3F800000, 2'b10, {4'b0000, 32'h7F800000}, 1, 0);
    do_op("1-inf",    32'h3F800000, 32'h7F800000, 2'b01, {4'b0000, 32'hFF800000}, 1, 0);
    do_op("den+1",    32'h00000001, 32'h3F800000, 2'b10, {4'b0000, 32'h3F800000}, 1, 0);
    do_op("1+tiny",   32'h3F800000, 32'h30800000, 2'b10, {4'b0001, 32'h3F800000}, 1, 0);
    do_op("1-2^-24",  32'h3F800000, 32'h33800000, 2'b01, {4'b0000, 32'h3F7FFFFF}, 1, 0);
    do_op("1-2^-25",  32'h3F800000, 32'h33000000, 2'b01, {4'b0001, HALF_RES},      1, 0);
    do_op("1.5+1.5",  32'h3FC00000, 32'h3FC00000, 2'b10, {4'b0000, 32'h40400000}, 1, 0);

    reset_abort();
    do_op("unf",      32'h00800001, 32'h00800000, 2'b01, {4'b0101, 32'h00000000}, 1, 0);

    for (int i = 0; i < 60; i++) begin
      ea = int'($urandom_range(100, 150));
      eb = ea + int'($urandom_range(0, 60)) - 30;
      ra = {1'($urandom), 8'(ea), 23'($urandom)};
      rb = {1'($urandom), 8'(eb), 23'($urandom)};
      if (i % 3 == 0) rb = {~ra[31], ra[30:23], ra[22:0] ^ 23'($urandom_range(0, 255))};
      do_op("rand", ra, rb, 2'($urandom), '0, 0, 0);
    end

    repeat (3) @(negedge CLK);
    nvec++;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL pending: got %0d results never delivered, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
